// File: rtl/flash_arbiter_pkg.sv
// Shared definitions for the QPI flash bus arbiter: state encoding and the
// pin bundle driven toward the flash pad logic.
package flash_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef struct packed {
    logic       nce;
    logic       sclk;
    logic [3:0] sout;
    logic       oe;
    logic       bus_qpi;
  } pins_t;

  // Safe pin state whenever nobody owns the bus: chip deselected, clock low,
  // data lines not driven.
  localparam pins_t PINS_IDLE = '{nce: 1'b1, sclk: 1'b0, sout: 4'h0, oe: 1'b0, bus_qpi: 1'b0};

endpackage

// File: rtl/flash_arbiter_rr_pick.sv
// Combinational request picker: first set request at or after rr (wrapping),
// or the lowest set request when fixed is high.
module rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr,
  input  logic         fixed,
  output logic         valid,
  output logic [W-1:0] index
);

  int   start;
  logic found;

  always_comb begin
    start = fixed ? 0 : int'(rr);
    found = 1'b0;
    index = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (!found && req[j]) begin
        index = W'(j);
        found = 1'b1;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/flash_arbiter.sv
// Shares one QPI flash bus among NMASTER controllers with hold-until-release
// ownership and a forced chip-select-high gap between owners.
module flash_arbiter
  import flash_arbiter_pkg::*;
#(
  parameter int NMASTER    = 2,
  parameter int CS_GAP     = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NMASTER-1:0]     m_req,
  output logic [NMASTER-1:0]     m_gnt,
  input  logic [NMASTER-1:0]     m_nce,
  input  logic [NMASTER-1:0]     m_sclk,
  input  logic [4*NMASTER-1:0]   m_sout,
  input  logic [NMASTER-1:0]     m_oe,
  input  logic [NMASTER-1:0]     m_bus_qpi,
  output logic [3:0]             m_sin,
  output logic                   flash_nce,
  output logic                   flash_sclk,
  output logic [3:0]             flash_sout,
  output logic                   flash_oe,
  output logic                   flash_bus_qpi,
  input  logic [3:0]             flash_sin,
  output logic                   flash_selected,
  output logic                   busy
);

  localparam int OW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
  localparam int CW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  logic [1:0]         state;
  logic [OW-1:0]      owner;
  logic [OW-1:0]      rr;
  logic [NMASTER-1:0] gnt;
  logic [CW-1:0]      gap_cnt;

  logic               pick_valid;
  logic [OW-1:0]      pick_idx;
  logic               take;
  pins_t              own_pins;
  pins_t              pins;

  rr_pick #(.N(NMASTER), .W(OW)) u_pick (
    .req   (m_req),
    .rr    (rr),
    .fixed (FIXED_PRIO != 0),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Arbitration happens from IDLE, or at the last GAP cycle so a waiting
  // master is granted without passing through IDLE.
  assign take = pick_valid &&
                ((state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == '0)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      owner   <= '0;
      rr      <= '0;
      gnt     <= '0;
      gap_cnt <= '0;
    end else if (take) begin
      state <= ST_GRANT;
      owner <= pick_idx;
      gnt   <= NMASTER'(1) << pick_idx;
      rr    <= OW'((int'(pick_idx) + 1) % NMASTER);
    end else begin
      case (state)
        ST_IDLE: ;
        ST_GRANT: begin
          if (!m_req[owner]) begin
            gnt     <= '0;
            state   <= ST_GAP;
            gap_cnt <= CW'(CS_GAP - 1);
          end
        end
        ST_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - CW'(1);
          else               state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pins follow the registered owner only; m_req never reaches the pads.
  always_comb begin
    own_pins = '{nce:     m_nce[owner],
                 sclk:    m_sclk[owner],
                 sout:    m_sout[int'(owner)*4 +: 4],
                 oe:      m_oe[owner],
                 bus_qpi: m_bus_qpi[owner]};
    pins = (state == ST_GRANT) ? own_pins : PINS_IDLE;
  end

  assign flash_nce      = pins.nce;
  assign flash_sclk     = pins.sclk;
  assign flash_sout     = pins.sout;
  assign flash_oe       = pins.oe;
  assign flash_bus_qpi  = pins.bus_qpi;
  assign flash_selected = (state == ST_GRANT);
  assign busy           = (state != ST_IDLE);
  assign m_gnt          = gnt;
  assign m_sin          = flash_sin;

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: a round-robin and a fixed-priority instance share
// stimulus; directed scenarios plus random traffic against a queue-free model.
module tb_flash_arbiter;

  localparam int N   = 2;
  localparam int GAP = 2;

  logic         clk = 1'b0;
  logic         rstn;
  logic [1:0]   m_req, m_nce, m_sclk, m_oe, m_qpi;
  logic [7:0]   m_sout;
  logic [3:0]   flash_sin;

  logic [1:0]   rr_gnt, fp_gnt;
  logic [3:0]   rr_sin, fp_sin, rr_sout, fp_sout;
  logic         rr_nce, rr_sclk, rr_oe, rr_qpi, rr_sel, rr_busy;
  logic         fp_nce, fp_sclk, fp_oe, fp_qpi, fp_sel, fp_busy;
  logic [15:0]  rr_obs, fp_obs;

  int checks = 0;
  int errors = 0;

  int mo_own[2];
  int mo_gap[2];
  int mo_rr[2];

  always #5 clk = ~clk;

  flash_arbiter #(.NMASTER(N), .CS_GAP(GAP), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_gnt(rr_gnt), .m_nce(m_nce),
    .m_sclk(m_sclk), .m_sout(m_sout), .m_oe(m_oe), .m_bus_qpi(m_qpi),
    .m_sin(rr_sin), .flash_nce(rr_nce), .flash_sclk(rr_sclk),
    .flash_sout(rr_sout), .flash_oe(rr_oe), .flash_bus_qpi(rr_qpi),
    .flash_sin(flash_sin), .flash_selected(rr_sel), .busy(rr_busy));

  flash_arbiter #(.NMASTER(N), .CS_GAP(GAP), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_gnt(fp_gnt), .m_nce(m_nce),
    .m_sclk(m_sclk), .m_sout(m_sout), .m_oe(m_oe), .m_bus_qpi(m_qpi),
    .m_sin(fp_sin), .flash_nce(fp_nce), .flash_sclk(fp_sclk),
    .flash_sout(fp_sout), .flash_oe(fp_oe), .flash_bus_qpi(fp_qpi),
    .flash_sin(flash_sin), .flash_selected(fp_sel), .busy(fp_busy));

  assign rr_obs = {rr_gnt, rr_nce, rr_sclk, rr_sout, rr_oe, rr_qpi, rr_sel, rr_busy, rr_sin};
  assign fp_obs = {fp_gnt, fp_nce, fp_sclk, fp_sout, fp_oe, fp_qpi, fp_sel, fp_busy, fp_sin};

  // Reference: owner -1 = nobody, gap -1 = not gapping, else cycles left after this one.
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mo_own[i] = -1;
      mo_gap[i] = -1;
      mo_rr[i]  = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [1:0] req, input bit fixed);
    bit pick;
    pick = 1'b0;
    if (mo_own[i] >= 0) begin
      if (!req[mo_own[i]]) begin
        mo_own[i] = -1;
        mo_gap[i] = GAP - 1;
      end
    end else if (mo_gap[i] > 0) begin
      mo_gap[i]--;
    end else begin
      mo_gap[i] = -1;
      pick = 1'b1;
    end
    if (pick) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = ((fixed ? 0 : mo_rr[i]) + k) % N;
        if (req[j] && mo_own[i] < 0) begin
          mo_own[i] = j;
          mo_rr[i]  = (j + 1) % N;
        end
      end
    end
  endtask

  function automatic logic [15:0] expected(input int i);
    int o;
    o = mo_own[i];
    if (o >= 0)
      return {2'(1 << o), m_nce[o], m_sclk[o], m_sout[4*o +: 4], m_oe[o], m_qpi[o], 1'b1, 1'b1, flash_sin};
    return {2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, mo_gap[i] >= 0, flash_sin};
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; m_req = 2'b00; m_nce = 2'b00; m_sclk = 2'b11; m_oe = 2'b11;
    m_qpi = 2'b11; m_sout = 8'hFF; flash_sin = 4'h0;
    #2;
    checks++; if (rr_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", rr_gnt); end
    checks++; if (rr_nce !== 1'b1) begin errors++; $display("FAIL reset_nce: got %b want 1", rr_nce); end
    checks++; if ({rr_sclk, rr_sout, rr_oe, rr_qpi} !== 7'h0) begin errors++; $display("FAIL reset_pins: got %h want 0", {rr_sclk, rr_sout, rr_oe, rr_qpi}); end
    checks++; if ({rr_sel, rr_busy} !== 2'b00) begin errors++; $display("FAIL reset_sel_busy: got %b want 00", {rr_sel, rr_busy}); end
    @(negedge clk) rstn = 1'b1;
    m_nce = 2'b11; m_sclk = 2'b00; m_oe = 2'b00; m_qpi = 2'b00; m_sout = 8'h00;
  endtask

  task automatic test_single();
    @(negedge clk);
    m_req = 2'b01; m_nce = 2'b10; m_sout = 8'h0A; flash_sin = 4'h5;
    #1;
    checks++; if (rr_gnt !== 2'b00) begin errors++; $display("FAIL single_latency: got %b want 00", rr_gnt); end
    step_clk();
    checks++; if (rr_gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", rr_gnt); end
    checks++; if (rr_sout !== 4'hA) begin errors++; $display("FAIL single_sout: got %h want a", rr_sout); end
    checks++; if (rr_nce !== 1'b0) begin errors++; $display("FAIL single_nce: got %b want 0", rr_nce); end
    checks++; if (rr_sin !== 4'h5) begin errors++; $display("FAIL single_sin: got %h want 5", rr_sin); end
    checks++; if ({rr_sel, rr_busy} !== 2'b11) begin errors++; $display("FAIL single_sel_busy: got %b want 11", {rr_sel, rr_busy}); end
    m_sout = 8'hF7;
    #1;
    checks++; if (rr_sout !== 4'h7) begin errors++; $display("FAIL single_mux: got %h want 7", rr_sout); end
    m_req = 2'b00;
    step_clk();
    checks++; if ({rr_gnt, rr_nce, rr_sel, rr_busy} !== 5'b00101) begin errors++; $display("FAIL single_release: got %b want 00101", {rr_gnt, rr_nce, rr_sel, rr_busy}); end
    step_clk();
    checks++; if (rr_busy !== 1'b1) begin errors++; $display("FAIL single_gap_hold: got %b want 1", rr_busy); end
    step_clk();
    checks++; if (rr_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", rr_busy); end
  endtask

  task automatic test_abort();
    @(negedge clk);
    m_req = 2'b01; m_nce = 2'b00; m_sclk = 2'b01; m_oe = 2'b01;
    step_clk();
    checks++; if ({rr_sclk, rr_oe} !== 2'b11) begin errors++; $display("FAIL abort_active: got %b want 11", {rr_sclk, rr_oe}); end
    m_req = 2'b00;
    step_clk();
    checks++; if ({rr_nce, rr_sclk, rr_oe, rr_sel} !== 4'b1000) begin errors++; $display("FAIL abort_cut: got %b want 1000", {rr_nce, rr_sclk, rr_oe, rr_sel}); end
    step_clk();
    step_clk();
    checks++; if ({rr_busy, rr_sclk, rr_nce} !== 3'b001) begin errors++; $display("FAIL abort_idle: got %b want 001", {rr_busy, rr_sclk, rr_nce}); end
    m_sclk = 2'b00; m_oe = 2'b00;
  endtask

  task automatic test_reset_mid_grant();
    m_req = 2'b01; m_nce = 2'b00;
    step_clk();
    checks++; if ({rr_gnt, rr_nce} !== 3'b010) begin errors++; $display("FAIL rstmid_pre: got %b want 010", {rr_gnt, rr_nce}); end
    #2 rstn = 1'b0;
    #1;
    checks++; if ({rr_gnt, rr_nce, rr_busy, rr_sel} !== 5'b00100) begin errors++; $display("FAIL rstmid_async: got %b want 00100", {rr_gnt, rr_nce, rr_busy, rr_sel}); end
    m_req = 2'b00;
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [4];
    int ngr, held, hi;
    for (int k = 0; k < 4; k++) seq[k] = 2'b00;
    ngr = 0; held = 0; hi = 0;
    @(negedge clk);
    m_nce = 2'b00; m_req = 2'b11;
    for (int c = 0; c < 120 && ngr < 4; c++) begin
      step_clk();
      m_req = 2'b11;
      if (rr_gnt != 2'b00) begin
        if (held == 0) begin
          seq[ngr] = rr_gnt;
          if (ngr > 0) begin
            checks++; if (hi != GAP) begin errors++; $display("FAIL rr_gap_len: got %0d want %0d", hi, GAP); end
          end
          ngr++;
          hi = 0;
        end
        held++;
        if (held == 8) begin
          m_req = m_req & ~rr_gnt;
          held = 0;
        end
      end else if (rr_nce) begin
        hi++;
      end
    end
    checks++; if (ngr != 4) begin errors++; $display("FAIL rr_timeout: got %0d grants want 4", ngr); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (seq[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", k, seq[k], (k % 2 == 0) ? 2'b01 : 2'b10); end
    end
    m_req = 2'b00;
    repeat (4) step_clk();
  endtask

  task automatic test_gap_back_to_back();
    m_req = 2'b01;
    step_clk();
    checks++; if (rr_gnt !== 2'b01) begin errors++; $display("FAIL b2b_first: got %b want 01", rr_gnt); end
    m_req = 2'b10;
    step_clk();
    checks++; if ({rr_gnt, rr_busy, rr_nce} !== 4'b0011) begin errors++; $display("FAIL b2b_gap1: got %b want 0011", {rr_gnt, rr_busy, rr_nce}); end
    step_clk();
    checks++; if ({rr_gnt, rr_busy, rr_nce} !== 4'b0011) begin errors++; $display("FAIL b2b_gap2: got %b want 0011", {rr_gnt, rr_busy, rr_nce}); end
    step_clk();
    checks++; if (rr_gnt !== 2'b10) begin errors++; $display("FAIL b2b_grant: got %b want 10", rr_gnt); end
    m_req = 2'b00;
    repeat (4) step_clk();
  endtask

  task automatic test_fixed_prio();
    m_req = 2'b11;
    step_clk();
    checks++; if (fp_gnt !== 2'b01) begin errors++; $display("FAIL fp_first: got %b want 01", fp_gnt); end
    repeat (3) step_clk();
    for (int r = 0; r < 3; r++) begin
      m_req = 2'b10;
      step_clk();
      checks++; if ({fp_gnt, fp_busy} !== 3'b001) begin errors++; $display("FAIL fp_gap[%0d]: got %b want 001", r, {fp_gnt, fp_busy}); end
      m_req = 2'b11;
      step_clk();
      step_clk();
      checks++; if (fp_gnt !== 2'b01) begin errors++; $display("FAIL fp_regrant[%0d]: got %b want 01", r, fp_gnt); end
      step_clk();
    end
    m_req = 2'b00;
    repeat (4) step_clk();
  endtask

  task automatic test_random();
    rstn = 1'b0; m_req = 2'b00;
    #3;
    model_reset();
    @(negedge clk) rstn = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      model_step(0, m_req, 1'b0);
      model_step(1, m_req, 1'b1);
      #2;
      for (int b = 0; b < N; b++) if ($urandom_range(3) == 0) m_req[b] = ~m_req[b];
      m_nce     = 2'($urandom);
      m_sclk    = 2'($urandom);
      m_oe      = 2'($urandom);
      m_qpi     = 2'($urandom);
      m_sout    = 8'($urandom);
      flash_sin = 4'($urandom);
      #2;
      checks++; if (rr_obs !== expected(0)) begin errors++; $display("FAIL random_rr cycle %0d: got %h want %h", c, rr_obs, expected(0)); end
      checks++; if (fp_obs !== expected(1)) begin errors++; $display("FAIL random_fp cycle %0d: got %h want %h", c, fp_obs, expected(1)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_abort();
    test_reset_mid_grant();
    test_round_robin();
    test_gap_back_to_back();
    test_fixed_prio();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_arbiter.md
Name: flash_arbiter

Overview:
- Shares the single QPI flash bus between NMASTER requesters, e.g. the CPU flash cache and a flash programming/loader port.
- Sits between the requesters' flash controllers and the flash pin logic: tristate buffers and the user master-clock primitive.
- Round-robin grant, hold-until-release ownership, and an enforced chip-select gap between owners.
- Drives the pins to a safe idle state whenever no master owns the bus.

Parameters:
NMASTER, 2, number of requesters (2..4)
CS_GAP, 2, cycles flash_nce is forced high after an owner releases (>=1)
FIXED_PRIO, 0, 1 = lowest index always wins; 0 = round-robin

Ports:
clk  in  1  system clock (48 MHz domain)
rstn  in  1  reset, asynchronous, active-low
m_req  in  NMASTER  per-master bus request; held for the whole ownership
m_gnt  out  NMASTER  per-master grant, one-hot or zero
m_nce  in  NMASTER  per-master chip select, active-low
m_sclk  in  NMASTER  per-master serial clock
m_sout  in  4*NMASTER  per-master data out, master i at bits [4i+3:4i]
m_oe  in  NMASTER  per-master output enable
m_bus_qpi  in  NMASTER  per-master QPI-mode flag
m_sin  out  4  flash input data, broadcast to all masters
flash_nce  out  1  to flash CS pin
flash_sclk  out  1  to user master-clock primitive
flash_sout  out  4  to tristate I inputs
flash_oe  out  1  to tristate control
flash_bus_qpi  out  1  to tristate control
flash_sin  in  4  from tristate O outputs
flash_selected  out  1  high while any master is granted
busy  out  1  state != IDLE

Behaviour:
- Reset (rstn low, takes effect asynchronously):
  - State goes to IDLE; rr pointer = 0.
  - m_gnt = 0; flash_nce = 1; flash_sclk = 0; flash_sout = 0; flash_oe = 0; flash_bus_qpi = 0; flash_selected = 0; busy = 0.
- State machine IDLE / GRANT / GAP; register `owner` holds log2(NMASTER) bits.
- IDLE:
  - If any m_req is high at a rising edge, pick a winner, set owner, and go to GRANT on that same edge.
  - m_gnt[owner] is registered and rises on that edge, giving 1-cycle latency from request to grant.
- Winner selection:
  - FIXED_PRIO=1: lowest set index wins.
  - FIXED_PRIO=0: the first set index searching from rr, wrapping; when a grant is taken, rr = owner+1 mod NMASTER.
- GRANT:
  - Flash outputs are a combinational mux of the owner's signals, selected by the registered owner only; there is no path from m_req to the pins.
  - m_sin = flash_sin at all times; non-owners must ignore it.
  - flash_selected = 1.
- Release:
  - Owner drops m_req at an edge -> m_gnt = 0 on that edge; go to GAP with gap counter = CS_GAP-1.
- GAP:
  - flash_nce forced to 1; sclk/sout/oe/bus_qpi forced to 0; flash_selected = 0.
  - Counter decrements each cycle. At 0 with requests pending, arbitrate exactly as in IDLE and go straight to GRANT on the same edge; with none pending, go to IDLE.
  - Minimum nce-high time between owners is therefore CS_GAP cycles.
- Safety cases:
  - Owner drops m_req while its m_nce is low: the forced nce=1 in GAP terminates the transaction. No error flag.
  - Requests from non-owners during GRANT are ignored until GAP ends; no preemption.
  - Simultaneous release by the owner and a new request in the same cycle: the GAP is still enforced.
- m_req is assumed synchronous to clk; no internal synchronizers.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, GRANT=2'd1, GAP=2'd2) and the idle-pin constants.
- One sub-module, rr_pick: a combinational round-robin/fixed priority picker. Inputs: req vector, rr, fixed flag. Outputs: valid, index. Reusable by other bus arbiters in the SoC.

Test Plan:
- Reset idle: rstn low mid-GRANT with m_nce[0]=0 -> flash_nce=1, m_gnt=0, busy=0 immediately, without waiting for a clk edge.
- Single master: m_req=01 at edge 10 -> m_gnt=01 after edge 10. m_sout[3:0]=4'hA, m_nce[0]=0 -> flash_sout=4'hA, flash_nce=0 in the same cycle. flash_sin=4'h5 -> m_sin=4'h5.
- Round-robin: m_req=11 held, each master releases after 8 cycles of grant, CS_GAP=2 -> grants alternate 01,10,01,10; flash_nce high for exactly 2 cycles between owners.
- Fixed priority (FIXED_PRIO=1): m_req=11 held, master 0 releases and re-requests during GAP -> master 0 regranted and master 1 starves, as specified.
- Abort: owner drops m_req with m_nce=0, m_sclk=1 -> next cycle flash_nce=1, flash_sclk=0, flash_oe=0, flash_selected=0.
- Gap back-to-back: master 1 requests during master 0's GAP -> m_gnt=10 on the edge where the gap counter reaches 0, with no IDLE cycle in between.
